pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 66 ++++++
 rtl/pipeline_hazard_ctrl_hazard_compare.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encoding, register address width,
// the NOP word the stage registers load on flush, and the per-cycle control
// bundle driven into the stage registers and the PC.
package pipeline_hazard_ctrl_pkg;

  // Default register-file address width used across the pipeline.
  localparam int REG_ADDR_W = 5;

  // Instruction word a stage register holds after a flush (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  // One cycle's worth of stage-register and PC control.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctrl_t;

  // Whole pipeline held: nothing advances, nothing is cleared.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0
  };

  // No hazard: every stage advances.
  localparam ctrl_t CTRL_PASS = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1
  };

  // Taken branch: fetch the target, kill the two younger instructions.
  localparam ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1
  };

  // Load-use: hold PC and IF/ID, insert one bubble into EX, drain the rest.
  localparam ctrl_t CTRL_BUBBLE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1
  };

  // Branch and load-use resolution once memory is not holding the pipe.
  // A taken branch wins because it kills the ID instruction that would
  // otherwise have needed the bubble.
  function automatic ctrl_t resolve_hazards(input logic br_taken,
                                            input logic load_use);
    if (br_taken) begin
      return CTRL_BRANCH;
    end else if (load_use) begin
      return CTRL_BUBBLE;
    end
    return CTRL_PASS;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Load-use detection: a load in EX whose destination is read by the
// instruction in ID. Register 0 is hard-wired and never creates a hazard.
// Purely combinational so the forwarding unit can reuse it.
module hazard_compare #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  // Compare the EX destination against both ID source fields.
  always_comb begin
    rd_nonzero = (ex_rd != '0);
    rs_match   = (ex_rd == id_rs);
    rt_match   = id_uses_rt && (ex_rd == id_rt);
    load_use   = ex_mem_read && rd_nonzero && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Drives the PC
// and stage-register enables/flushes for load-use bubbles, taken-branch
// flushes and multi-cycle data-memory waits, with a memory-wait watchdog
// and a saturating stall-cycle counter for debug.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = pipeline_hazard_ctrl_pkg::REG_ADDR_W,
  // Longest tolerated memory access in cycles; must be at least 2.
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  br_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              timeout_nxt;
  logic              load_use;
  logic              mem_busy;
  ctrl_t             ctrl;

  hazard_compare #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_compare (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_busy = mem_req && !mem_ready;

  // State register, watchdog counter and sticky timeout flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  // Next-state logic: enter the wait on a stalled access, leave on ready,
  // trip the watchdog when the wait reaches MEM_TIMEOUT cycles.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_nxt = mem_timeout;
    unique case (state)
      ST_RUN: begin
        if (mem_busy) begin
          state_nxt = ST_MEM_WAIT;
          wcnt_nxt  = WCNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = ST_RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt   = ST_ERR;
          timeout_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + WCNT_ONE;
        end
      end
      ST_ERR: begin
        timeout_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Output logic: same-cycle control from state and current hazards.
  // Branch/load-use are only looked at when memory is not holding the pipe.
  always_comb begin
    ctrl = CTRL_FREEZE;
    unique case (state)
      ST_RUN: begin
        if (!mem_busy) begin
          ctrl = resolve_hazards(br_taken, load_use);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          ctrl = resolve_hazards(br_taken, load_use);
        end
      end
      default: begin
        ctrl = CTRL_FREEZE;
      end
    endcase
    if (rst) begin
      ctrl = CTRL_FREEZE;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;

  // Debug counter of cycles with the PC held; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of same-cycle RUN vectors
// followed by hand-written multi-cycle sequences (stall count, memory wait,
// watchdog, asynchronous reset, counter saturation).
module tb_pipeline_hazard_ctrl;

  localparam int RW    = 5;
  localparam int MTO   = 16;
  localparam int CW    = 4;

  // Expected control, ordered {pc_en, if_id_en, if_id_flush, id_ex_flush,
  // ex_mem_en, mem_wb_en}.
  localparam logic [5:0] E_PASS   = 6'b110011;
  localparam logic [5:0] E_BUBBLE = 6'b000111;
  localparam logic [5:0] E_FLUSH  = 6'b111111;
  localparam logic [5:0] E_FREEZE = 6'b000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] id_rs = '0;
  logic [RW-1:0] id_rt = '0;
  logic          id_uses_rt = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic [RW-1:0] ex_rd = '0;
  logic          br_taken = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (RW),
    .MEM_TIMEOUT (MTO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] rd;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [5:0] exp_ctrl;
  } vec_t;

  function automatic logic [5:0] ctrl_now();
    return {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mrd, input logic [4:0] rd,
                        input logic br, input logic mreq, input logic mrdy);
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = urt;
    ex_mem_read = mrd;
    ex_rd       = rd;
    br_taken    = br;
    mem_req     = mreq;
    mem_ready   = mrdy;
  endtask

  task automatic clear_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pulse reset across a full clock period, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net: the whole run is a few hundred cycles.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    vecs[0]  = '{"idle",          5'd3,  5'd4,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, E_PASS};
    vecs[1]  = '{"lu_rs",         5'd5,  5'd1,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, E_BUBBLE};
    vecs[2]  = '{"lu_r0",         5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, E_PASS};
    vecs[3]  = '{"lu_rt",         5'd2,  5'd5,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, E_BUBBLE};
    vecs[4]  = '{"rt_unused",     5'd3,  5'd5,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, E_PASS};
    vecs[5]  = '{"no_load",       5'd5,  5'd5,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, E_PASS};
    vecs[6]  = '{"br_and_lu",     5'd5,  5'd1,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, E_FLUSH};
    vecs[7]  = '{"br_only",       5'd1,  5'd2,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, E_FLUSH};
    vecs[8]  = '{"mem_done_lu",   5'd7,  5'd0,  1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, E_BUBBLE};
    vecs[9]  = '{"lu_r31",        5'd31, 5'd0,  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, E_BUBBLE};
    vecs[10] = '{"lu_rt_other",   5'd6,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, E_BUBBLE};

    // Reset state, with no-hazard inputs that would otherwise enable all.
    rst = 1'b1;
    set_in(5'd3, 5'd4, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_ctrl", 32'(ctrl_now()), 32'(E_FREEZE));
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    do_reset();

    // Same-cycle RUN vectors; none leave RUN.
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read,
             vecs[i].rd, vecs[i].br, vecs[i].mreq, vecs[i].mrdy);
      #1;
      check(vecs[i].name, 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
      @(negedge clk);
    end

    // Load-use counts one stall cycle; register 0 does not.
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_seq_ctrl", 32'(ctrl_now()), 32'(E_BUBBLE));
    tick();
    check("lu_seq_cnt", 32'(stall_cnt), 32'd1);
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("r0_seq_ctrl", 32'(ctrl_now()), 32'(E_PASS));
    tick();
    check("r0_seq_cnt", 32'(stall_cnt), 32'd1);

    // Branch over a load-use: flushes, no stall counted.
    @(negedge clk);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check("br_lu_ctrl", 32'(ctrl_now()), 32'(E_FLUSH));
    tick();
    check("br_lu_cnt", 32'(stall_cnt), 32'd1);

    // Three-cycle memory wait, released with ready; branch ignored while frozen.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      br_taken = (c == 1);
      #1;
      check($sformatf("mw_freeze%0d", c), 32'(ctrl_now()), 32'(E_FREEZE));
      @(negedge clk);
    end
    br_taken  = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("mw_release", 32'(ctrl_now()), 32'(E_PASS));
    tick();
    check("mw_cnt", 32'(stall_cnt), 32'd3);
    @(negedge clk);
    clear_in();
    #1;
    check("mw_run_after", 32'(ctrl_now()), 32'(E_PASS));

    // Release cycle applies load-use: a bubble, then back in RUN.
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1);
    #1;
    check("mw_release_lu", 32'(ctrl_now()), 32'(E_BUBBLE));
    @(negedge clk);
    clear_in();

    // Watchdog: 16 busy cycles trip it, not 15.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      tick();
    end
    check("wd_not_yet", 32'(mem_timeout), 32'd0);
    tick();
    check("wd_tripped", 32'(mem_timeout), 32'd1);
    check("wd_cnt_sat", 32'(stall_cnt), 32'd15);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("err_ctrl", 32'(ctrl_now()), 32'(E_FREEZE));
    tick();
    tick();
    check("err_sticky", 32'(mem_timeout), 32'd1);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_ctrl", 32'(ctrl_now()), 32'(E_FREEZE));
    check("arst_timeout", 32'(mem_timeout), 32'd0);
    check("arst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    clear_in();
    rst = 1'b0;
    #1;
    check("arst_run", 32'(ctrl_now()), 32'(E_PASS));
    tick();
    check("arst_run_edge", 32'(ctrl_now()), 32'(E_PASS));
    check("arst_cnt_idle", 32'(stall_cnt), 32'd0);

    // Saturation: 2^4+5 stall cycles, counter stops at 15.
    do_reset();
    set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 14) check("sat_14", 32'(stall_cnt), 32'd14);
      if (c == 15) check("sat_15", 32'(stall_cnt), 32'd15);
    end
    check("sat_hold", 32'(stall_cnt), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
